// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle core: sequences ALU, register file, PC and
// the unified memory across fetch/decode/execute/memory/write-back states.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic [1:0]       ALUOp_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic             IRWrite_o,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic             IorD_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             RegWrite_o,
    output logic             MemtoReg_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_EXEC_I   = 4'd9
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;

    logic [1:0] w_alu_op;
    logic       w_src_a;
    logic [1:0] w_src_b;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_mem_to_reg;
    logic       w_illegal;

    // State register and retired-instruction counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next          = S_FETCH;
        w_retire        = 1'b0;
        w_alu_op        = 2'b00;
        w_src_a         = 1'b0;
        w_src_b         = 2'b00;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_illegal       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_src_b    = 2'b01;
                w_ir_write = mem_ready_i;
                w_pc_write = mem_ready_i;
                w_next     = mem_ready_i ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_src_b = 2'b10;
                case (opcode_i)
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                    OP_RTYPE:          w_next = S_EXEC_R;
                    OP_ITYPE:          w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_src_a = 1'b1;
                w_src_b = 2'b10;
                w_next  = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
                w_next     = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = mem_ready_i;
                w_next      = mem_ready_i ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
                w_src_a  = 1'b1;
                w_alu_op = 2'b10;
                w_next   = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_src_a  = 1'b1;
                w_src_b  = 2'b10;
                w_alu_op = 2'b11;
                w_next   = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_src_a         = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = zero_i;
                w_retire        = 1'b1;
                w_next          = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset forces every strobe low, even before the first clock edge
    assign ALUOp_o       = rst_i ? 2'b00 : w_alu_op;
    assign ALUSrcA_o     = ~rst_i & w_src_a;
    assign ALUSrcB_o     = rst_i ? 2'b00 : w_src_b;
    assign IRWrite_o     = ~rst_i & w_ir_write;
    assign PCWrite_o     = ~rst_i & w_pc_write;
    assign PCWriteCond_o = ~rst_i & w_pc_write_cond;
    assign IorD_o        = ~rst_i & w_iord;
    assign MemRead_o     = ~rst_i & w_mem_read;
    assign MemWrite_o    = ~rst_i & w_mem_write;
    assign RegWrite_o    = ~rst_i & w_reg_write;
    assign MemtoReg_o    = ~rst_i & w_mem_to_reg;
    assign illegal_o     = ~rst_i & w_illegal;
    assign state_o       = rst_i ? 4'd0 : r_state;
    assign instret_o     = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, reset and wrap
// sequences, and randomized instructions against an instruction-level model.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [6:0]       opcode_i;
    logic             zero_i;
    logic             mem_ready_i;
    logic [1:0]       ALUOp_o;
    logic             ALUSrcA_o;
    logic [1:0]       ALUSrcB_o;
    logic             IRWrite_o;
    logic             PCWrite_o;
    logic             PCWriteCond_o;
    logic             IorD_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic             RegWrite_o;
    logic             MemtoReg_o;
    logic             illegal_o;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] instret_o;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_cnt  = 4'd0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .ALUOp_o(ALUOp_o), .ALUSrcA_o(ALUSrcA_o),
        .ALUSrcB_o(ALUSrcB_o), .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o),
        .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .illegal_o(illegal_o), .state_o(state_o), .instret_o(instret_o)
    );

    always #5 clk_i = ~clk_i;

    // {ALUOp, SrcA, SrcB, IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, RegWrite, MemtoReg, illegal}
    logic [13:0] w_ctrl;
    assign w_ctrl = {ALUOp_o, ALUSrcA_o, ALUSrcB_o, IRWrite_o, PCWrite_o, PCWriteCond_o,
                     IorD_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o, illegal_o};

    function automatic bit is_legal(input logic [6:0] op);
        return op == OP_LOAD || op == OP_STORE || op == OP_RTYPE ||
               op == OP_ITYPE || op == OP_BRANCH;
    endfunction

    // Control outputs a state should present, straight from the per-state output table
    function automatic logic [13:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                             input logic z, input logic [6:0] op);
        logic [1:0] aop = 2'b00, srcb = 2'b00;
        logic srca = 0, irw = 0, pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, rw = 0, m2r = 0, ill = 0;
        case (st)
            4'd0: begin srcb = 2'b01; mr = 1; irw = rdy; pcw = rdy; end
            4'd1: begin srcb = 2'b10; ill = !is_legal(op); end
            4'd2: begin srca = 1; srcb = 2'b10; end
            4'd3: begin iord = 1; mr = 1; end
            4'd4: begin rw = 1; m2r = 1; end
            4'd5: begin iord = 1; mw = 1; end
            4'd6: begin srca = 1; aop = 2'b10; end
            4'd7: begin rw = 1; end
            4'd8: begin srca = 1; aop = 2'b01; pcwc = z; end
            4'd9: begin srca = 1; srcb = 2'b10; aop = 2'b11; end
            default: ;
        endcase
        return {aop, srca, srcb, irw, pcw, pcwc, iord, mr, mw, rw, m2r, ill};
    endfunction

    // Instruction-level model: ordered list of states an opcode visits (without the trailing fetch)
    function automatic int path_len(input logic [6:0] op);
        if (op == OP_LOAD) return 5;
        if (op == OP_STORE || op == OP_RTYPE || op == OP_ITYPE) return 4;
        if (op == OP_BRANCH) return 3;
        return 2;
    endfunction

    function automatic logic [5:0][3:0] path_seq(input logic [6:0] op);
        logic [5:0][3:0] s = '0;
        s[0] = 4'd0;
        s[1] = 4'd1;
        if (op == OP_LOAD)   begin s[2] = 4'd2; s[3] = 4'd3; s[4] = 4'd4; end
        if (op == OP_STORE)  begin s[2] = 4'd2; s[3] = 4'd5; end
        if (op == OP_RTYPE)  begin s[2] = 4'd6; s[3] = 4'd7; end
        if (op == OP_ITYPE)  begin s[2] = 4'd9; s[3] = 4'd7; end
        if (op == OP_BRANCH) begin s[2] = 4'd8; end
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance past the edge
    task automatic step(input logic [6:0] op, input logic rdy, input logic z, input logic [3:0] st);
        opcode_i    = op;
        mem_ready_i = rdy;
        zero_i      = z;
        #1;
        chk($sformatf("state(exp %0d)", st), 32'(state_o), 32'(st));
        chk($sformatf("ctrl(st %0d)", st), 32'(w_ctrl), 32'(exp_ctrl(st, rdy, z, op)));
        chk($sformatf("instret(st %0d)", st), 32'(instret_o), 32'(exp_cnt));
        @(posedge clk_i);
        #1;
        if (st == 4'd4 || st == 4'd7 || st == 4'd8 || (st == 4'd5 && rdy)) exp_cnt = exp_cnt + 4'd1;
    endtask

    function automatic bit is_wait(input logic [3:0] st);
        return st == 4'd0 || st == 4'd3 || st == 4'd5;
    endfunction

    task automatic run_instr(input logic [6:0] op, input logic z, input int len,
                             input logic [5:0][3:0] seq, input int fst, input int mst,
                             input bit rnd);
        int idx = 0, wcnt = 0, steps = 0;
        logic rdy;
        logic [3:0] st;
        while (idx < len && steps < 64) begin
            st = seq[idx];
            if (is_wait(st)) begin
                if (rnd) rdy = ($urandom_range(0, 2) != 0) || wcnt >= 6;
                else     rdy = (wcnt >= ((st == 4'd0) ? fst : mst));
            end else begin
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            step(op, rdy, z, st);
            steps++;
            if (is_wait(st) && !rdy) wcnt++;
            else begin idx++; wcnt = 0; end
        end
        chk("cycle_budget", 32'(idx), 32'(len));
    endtask

    typedef struct {
        logic [6:0]      op;
        logic            z;
        int              len;
        logic [5:0][3:0] seq;   // seq[0] is the first state (rightmost nibble)
        int              fst;
        int              mst;
        int              ret;
    } vec_t;

    vec_t       tbl [8];
    logic [3:0] c0;

    initial begin
        tbl[0] = '{OP_RTYPE,  1'b0, 4, {4'd0, 4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 0, 0, 1};
        tbl[1] = '{OP_LOAD,   1'b0, 5, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 3, 2, 1};
        tbl[2] = '{OP_BRANCH, 1'b1, 3, {4'd0, 4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 0, 0, 1};
        tbl[3] = '{OP_BRANCH, 1'b0, 3, {4'd0, 4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 0, 0, 1};
        tbl[4] = '{7'b1111111, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 0, 0, 0};
        tbl[5] = '{OP_STORE,  1'b0, 4, {4'd0, 4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 1, 2, 1};
        tbl[6] = '{OP_ITYPE,  1'b1, 4, {4'd0, 4'd0, 4'd7, 4'd9, 4'd1, 4'd0}, 0, 0, 1};
        tbl[7] = '{OP_LOAD,   1'b0, 5, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 0, 0, 1};

        rst_i       = 1'b1;
        opcode_i    = '0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_ctrl", 32'(w_ctrl), 32'd0);
        chk("reset_instret", 32'(instret_o), 32'd0);
        #4 rst_i = 1'b0;

        // Directed vectors
        foreach (tbl[i]) begin
            c0 = instret_o;
            run_instr(tbl[i].op, tbl[i].z, tbl[i].len, tbl[i].seq, tbl[i].fst, tbl[i].mst, 1'b0);
            chk($sformatf("retired_vec%0d", i), 32'(4'(instret_o - c0)), 32'(tbl[i].ret));
        end

        // Asynchronous reset while a load waits in MEM_RD
        step(OP_LOAD, 1'b1, 1'b0, 4'd0);
        step(OP_LOAD, 1'b1, 1'b0, 4'd1);
        step(OP_LOAD, 1'b1, 1'b0, 4'd2);
        mem_ready_i = 1'b0;
        #1;
        chk("pre_reset_state", 32'(state_o), 32'd3);
        chk("pre_reset_instret_nonzero", 32'(instret_o != 4'd0), 32'd1);
        #2 rst_i = 1'b1;
        mem_ready_i = 1'b1;
        #1;
        chk("async_rst_state", 32'(state_o), 32'd0);
        chk("async_rst_ctrl", 32'(w_ctrl), 32'd0);
        chk("async_rst_instret", 32'(instret_o), 32'd0);
        exp_cnt = 4'd0;
        @(posedge clk_i);
        #1;
        chk("held_rst_state", 32'(state_o), 32'd0);
        chk("held_rst_ctrl", 32'(w_ctrl), 32'd0);
        #2 rst_i = 1'b0;
        run_instr(OP_RTYPE, 1'b0, path_len(OP_RTYPE), path_seq(OP_RTYPE), 0, 0, 1'b0);
        chk("post_reset_count", 32'(instret_o), 32'd1);

        // Sixteen I-type retirements wrap the 4-bit counter back to its start
        c0 = instret_o;
        for (int n = 0; n < 16; n++) begin
            run_instr(OP_ITYPE, 1'b0, path_len(OP_ITYPE), path_seq(OP_ITYPE), 0, 0, 1'b0);
        end
        chk("wrap16", 32'(instret_o), 32'(c0));
        while (exp_cnt != 4'd15)
            run_instr(OP_ITYPE, 1'b0, path_len(OP_ITYPE), path_seq(OP_ITYPE), 0, 0, 1'b0);
        run_instr(OP_ITYPE, 1'b0, path_len(OP_ITYPE), path_seq(OP_ITYPE), 0, 0, 1'b0);
        chk("wrap_15_to_0", 32'(instret_o), 32'd0);

        // Randomized instruction mix with random memory wait states
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            case ($urandom_range(0, 5))
                0: op = OP_LOAD;
                1: op = OP_STORE;
                2: op = OP_RTYPE;
                3: op = OP_ITYPE;
                4: op = OP_BRANCH;
                default: op = 7'($urandom);
            endcase
            run_instr(op, 1'($urandom_range(0, 1)), path_len(op), path_seq(op), 0, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
